// File: rtl/tinymips_pkg.sv
// Shared types for the TinyMIPS memory arbiter: FSM states and the RAM request bundle.
package tinymips_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W_MAX = 16;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    GRANT,
    RESUME
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_MAX-1:0] addr;
    logic [DATA_W-1:0]     data;
  } ram_req_t;

endpackage

// File: rtl/tinymips_mem_arbiter.sv
// Shares the single-port blram between the TinyMIPS core and the host/loader port.
// Define ARB_PERF_CNT_EN to add the saturating steal counter and its steal_cnt output.
module tinymips_mem_arbiter
  import tinymips_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int MIN_RUN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wrEn,
  input  logic [SIZE-1:0]   cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  output logic              cpu_rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [SIZE-1:0]   host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_start,
  input  logic              host_stop,
  output logic              ram_we,
  output logic [SIZE-1:0]   ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       steal_cnt
`endif
);

  localparam int            CW      = $clog2(MIN_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MIN_RUN);
  // The current RUN cycle counts toward MIN_RUN, so a steal fires on the MIN_RUN-th RUN cycle.
  localparam logic [CW-1:0] RUN_THR = CW'(MIN_RUN - 1);

  arb_state_t        state, stateNext;
  logic [CW-1:0]     runCnt;
  logic [DATA_W-1:0] shadow;
  logic [SIZE-1:0]   lastAddr;
  logic              rvalidQ;
  logic              hostSel;
  ram_req_t          cpuReq, hostReq, ramReq;
  logic              unusedAddrHi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    hostSel   = 1'b0;
    host_gnt  = 1'b0;
    cpu_hold  = 1'b0;
    cpu_rdata = ram_dout;
    case (state)
      BOOT: begin
        hostSel  = 1'b1;
        host_gnt = host_req;
        if (host_start && !host_req) stateNext = RUN;
      end
      RUN: begin
        if (host_stop)                          stateNext = BOOT;
        else if (host_req && runCnt >= RUN_THR) stateNext = GRANT;
      end
      GRANT: begin
        hostSel   = 1'b1;
        host_gnt  = 1'b1;
        cpu_hold  = 1'b1;
        stateNext = RESUME;
      end
      RESUME: begin
        cpu_rdata = shadow;
        stateNext = RUN;
      end
      default: stateNext = BOOT;
    endcase
  end

  assign cpuReq  = '{we: cpu_wrEn, addr: ADDR_W_MAX'(cpu_addr), data: cpu_wdata};
  assign hostReq = '{we: host_gnt & host_we, addr: ADDR_W_MAX'(host_addr), data: host_wdata};
  assign ramReq  = hostSel ? hostReq : cpuReq;

  assign ram_we       = ramReq.we;
  assign ram_addr     = ramReq.addr[SIZE-1:0];
  assign ram_din      = ramReq.data;
  assign unusedAddrHi = ^ramReq.addr;

  assign cpu_rst     = rst | (state == BOOT);
  assign host_rvalid = rvalidQ;
  assign host_rdata  = ram_dout;

  // Shadow captures the core's in-flight read during GRANT, patched by a colliding host write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      runCnt   <= RUN_MAX;
      shadow   <= '0;
      lastAddr <= '0;
      rvalidQ  <= 1'b0;
    end else begin
      rvalidQ <= host_gnt & ~host_we;
      case (state)
        RUN: begin
          lastAddr <= cpu_addr;
          if (runCnt != RUN_MAX) runCnt <= runCnt + 1'b1;
        end
        GRANT:   shadow <= (host_we && host_addr == lastAddr) ? host_wdata : ram_dout;
        RESUME:  runCnt <= '0;
        default: ;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         steal_cnt <= '0;
    else if (stateNext == BOOT && state != BOOT)     steal_cnt <= '0;
    else if (state == GRANT && steal_cnt != 16'hFFFF) steal_cnt <= steal_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tinymips_mem_arbiter.sv
// Randomized bench for tinymips_mem_arbiter with a blram model and a cycle-level reference model.
module tb_tinymips_mem_arbiter;

  localparam int SIZE    = 8;
  localparam int MIN_RUN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wrEn;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_hold;
  logic        cpu_rst;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic        host_start;
  logic        host_stop;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] steal_cnt;
`endif

  logic [15:0] blram  [0:255];
  logic [15:0] refMem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) blram[ram_addr] <= ram_din;
    ram_dout <= blram[ram_addr];
  end

  tinymips_mem_arbiter #(.SIZE(SIZE), .MIN_RUN(MIN_RUN)) dut (
    .clk(clk), .rst(rst),
    .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_hold(cpu_hold), .cpu_rst(cpu_rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_start(host_start), .host_stop(host_stop),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef ARB_PERF_CNT_EN
    , .steal_cnt(steal_cnt)
`endif
  );

  int nVectors     = 0;
  int nMiscompares = 0;

  // Reference model: mSteal 0 = core owns RAM, 1 = host cycle, 2 = core's catch-up cycle.
  bit          mBoot;
  int          mSteal;
  int          mRunSeen;
  bit          mRvalidPend;
  logic [15:0] mHostData;
  bit          mCoreValid;
  logic [7:0]  mCoreAddr;
  logic [15:0] mCoreData;
  int          mSteals;
  bit          lastGnt;
  int          obsHolds;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBoot       = 1'b1;
    mSteal      = 0;
    mRunSeen    = 1000;
    mRvalidPend = 1'b0;
    mCoreValid  = 1'b0;
    mSteals     = 0;
    lastGnt     = 1'b0;
  endtask

  task automatic checkModel();
    logic expGnt;
    expGnt = mBoot ? host_req : (mSteal == 1);
    checkVal("cpu_rst", cpu_rst, mBoot);
    checkVal("cpu_hold", cpu_hold, !mBoot && mSteal == 1);
    checkVal("host_gnt", host_gnt, expGnt);
    checkVal("host_rvalid", host_rvalid, mRvalidPend);
    if (mRvalidPend) checkVal("host_rdata", host_rdata, mHostData);
    if (!mBoot && mCoreValid) checkVal("cpu_rdata", cpu_rdata, mCoreData);
`ifdef ARB_PERF_CNT_EN
    checkVal("steal_cnt", steal_cnt, mSteals);
`endif
    obsHolds += int'(cpu_hold);
    lastGnt = expGnt;
  endtask

  task automatic updateModel();
    if (mBoot) begin
      mCoreValid  = 1'b0;
      mRvalidPend = host_req && !host_we;
      if (host_req) begin
        if (host_we) refMem[host_addr] = host_wdata;
        else         mHostData = refMem[host_addr];
      end
      if (host_start && !host_req) mBoot = 1'b0;
    end else if (mSteal == 1) begin
      mSteals++;
      if (host_we) begin
        refMem[host_addr] = host_wdata;
        if (host_addr == mCoreAddr) mCoreData = host_wdata;
        mRvalidPend = 1'b0;
      end else begin
        mHostData   = refMem[host_addr];
        mRvalidPend = 1'b1;
      end
      mSteal   = 2;
      mRunSeen = 0;
    end else begin
      mRvalidPend = 1'b0;
      mCoreData   = refMem[cpu_addr];
      mCoreAddr   = cpu_addr;
      mCoreValid  = 1'b1;
      if (cpu_wrEn) refMem[cpu_addr] = cpu_wdata;
      if (mSteal == 2) mSteal = 0;
      else begin
        if (host_stop) begin
          mBoot      = 1'b1;
          mCoreValid = 1'b0;
          mSteals    = 0;
        end else if (host_req && mRunSeen + 1 >= MIN_RUN) mSteal = 1;
        if (mRunSeen < 1000) mRunSeen++;
      end
    end
  endtask

  task automatic step(input logic req, input logic we, input logic [7:0] addr, input logic [15:0] wd,
                      input logic start, input logic stop,
                      input logic cwe, input logic [7:0] caddr, input logic [15:0] cwd);
    @(posedge clk);
    #1;
    host_req   = req;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wd;
    host_start = start;
    host_stop  = stop;
    cpu_wrEn   = cwe;
    cpu_addr   = caddr;
    cpu_wdata  = cwd;
    @(negedge clk);
    checkModel();
    updateModel();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'(14 + k % 6), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        pend, hWe, cWe, startP, stopP;
    logic [7:0]  hAddr, cAddr;
    logic [15:0] hWd, cWd, v;
    int          holdsBefore, prevGnt, nGr;

    rst = 1'b1;
    {host_req, host_we, host_start, host_stop, cpu_wrEn} = '0;
    host_addr = '0; host_wdata = '0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      blram[i]  <= v;
      refMem[i] = v;
    end
    modelReset();
    obsHolds = 0;
    repeat (2) @(negedge clk);
    checkVal("reset_cpu_rst", cpu_rst, 1'b1);
    checkVal("reset_cpu_hold", cpu_hold, 1'b0);
    checkVal("reset_host_gnt", host_gnt, 1'b0);
    checkVal("reset_host_rvalid", host_rvalid, 1'b0);
    rst = 1'b0;

    // BOOT: load data, then read it back
    step(1'b1, 1'b1, 8'd15, 16'd5, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    step(1'b1, 1'b1, 8'd19, 16'd22, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    for (int i = 0; i <= 10; i++) step(1'b1, 1'b1, 8'(i), 16'(i * 3 + 1), 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    step(1'b1, 1'b0, 8'd15, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    checkVal("boot_gnt_same_cycle", host_gnt, 1'b1);
    step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    checkVal("boot_rvalid", host_rvalid, 1'b1);
    checkVal("boot_rdata15", host_rdata, 16'd5);

    // start while a request is pending must be ignored
    step(1'b1, 1'b0, 8'd3, 16'd0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0);
    step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0);
    checkVal("start_ignored_with_req", cpu_rst, 1'b1);
    idle(1);
    checkVal("cpu_rst_fall", cpu_rst, 1'b0);

    // RUN: single read steal costs one hold cycle
    idle(4);
    holdsBefore = obsHolds;
    step(1'b1, 1'b0, 8'd19, 16'd0, 1'b0, 1'b0, 1'b0, 8'd17, 16'd0);
    step(1'b1, 1'b0, 8'd19, 16'd0, 1'b0, 1'b0, 1'b0, 8'd17, 16'd0);
    step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd18, 16'd0);
    checkVal("run_steal_rdata19", host_rdata, 16'd22);
    idle(4);
    checkVal("run_steal_hold_cycles", obsHolds - holdsBefore, 1);

    // steal writes the word the core is loading
    idle(3);
    step(1'b1, 1'b1, 8'd15, 16'h00AA, 1'b0, 1'b0, 1'b0, 8'd15, 16'd0);
    step(1'b1, 1'b1, 8'd15, 16'h00AA, 1'b0, 1'b0, 1'b0, 8'd15, 16'd0);
    step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd16, 16'd0);
    checkVal("coherent_resume_rdata", cpu_rdata, 16'h00AA);
    idle(3);

    // continuous host requests: grants spaced by RESUME + MIN_RUN RUN cycles
    prevGnt = -1;
    nGr = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 8'(i), 16'd0, 1'b0, 1'b0, i[0], 8'(20 + i % 8), 16'(i));
      if (host_gnt === 1'b1) begin
        if (prevGnt >= 0) checkVal("b2b_gap", i - prevGnt, MIN_RUN + 2);
        prevGnt = i;
        nGr++;
      end
    end
    checkVal("b2b_grants_seen", nGr >= 5, 1'b1);
    idle(4);

    // reset in the middle of a write steal: the write is lost
    step(1'b1, 1'b1, 8'd40, 16'h1234, 1'b0, 1'b0, 1'b0, 8'd3, 16'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("rst_mid_steal_hold", cpu_hold, 1'b1);
    rst = 1'b1;
    host_req = 1'b0;
    #1;
    checkVal("rst_mid_steal_cpu_rst", cpu_rst, 1'b1);
    checkVal("rst_mid_steal_gnt", host_gnt, 1'b0);
    checkVal("rst_mid_steal_cpu_hold", cpu_hold, 1'b0);
`ifdef ARB_PERF_CNT_EN
    checkVal("rst_mid_steal_steal_cnt", steal_cnt, 16'd0);
`endif
    modelReset();
    #2;
    rst = 1'b0;
    idle(2);
    step(1'b1, 1'b0, 8'd40, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    idle(1);

    // randomized traffic over a small address window to provoke collisions
    pend = 1'b0; hWe = 1'b0; hAddr = '0; hWd = '0;
    cWe = 1'b0; cAddr = '0; cWd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (pend && lastGnt) pend = 1'b0;
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend  = 1'b1;
        hWe   = 1'($urandom_range(0, 1));
        hAddr = 8'($urandom_range(0, 15));
        hWd   = 16'($urandom);
      end
      startP = mBoot && ($urandom_range(0, 5) == 0);
      stopP  = ($urandom_range(0, 39) == 0);
      if (mSteal != 1) begin
        cWe   = ($urandom_range(0, 2) == 0);
        cAddr = 8'($urandom_range(0, 15));
        cWd   = 16'($urandom);
      end
      step(pend, hWe, hAddr, hWd, startP, stopP, cWe, cAddr, cWd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
